// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: load/store funct3 codes,
// controller states and the store byte-enable helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Byte lanes touched by an access of the given (already legalised) size.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] off);
    case (size)
      F3_B, F3_BU: byte_en = 4'b0001 << off;
      F3_H, F3_HU: byte_en = off[1] ? 4'b1100 : 4'b0011;
      default:     byte_en = 4'b1111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// DEPTH_WORDS x 32 data RAM with per-byte write enables and a registered read port.
module dmem_bram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // rdata only moves on an enabled access, so it holds until the next request.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Valid/ready data-memory controller with RISC-V load/store sizing and RD_LAT read latency.
// Define DMEM_ERR_EN to enable misalignment/range/funct3 error reporting.
//
// state | meaning
// IDLE  | nothing in flight, counter 0
// BUSY  | request in flight, counter 1..RD_LAT-1
// RESP  | response cycle, counter RD_LAT; a new request may be accepted
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

  state_t      state;
  logic [2:0]  cnt;
  logic        accept;
  logic [2:0]  eff_size;
  logic [1:0]  eff_off;
  logic        acc_err;
  logic [31:0] wdata_rep;
  logic [3:0]  ram_we;
  logic [31:0] ram_rdata;
  logic [31:0] pipe_out;
  logic        m_we;
  logic        m_err;
  logic [2:0]  m_size;
  logic [1:0]  m_off;
  logic [31:0] shifted;
  logic [31:0] ext;

  assign req_ready = (state == IDLE) || (state == RESP);
  assign accept    = req_valid && req_ready && !rst;

`ifdef DMEM_ERR_EN
  always_comb begin
    eff_size = req_size;
    eff_off  = req_addr[1:0];
    if (req_we) acc_err = req_size > F3_W;
    else        acc_err = (req_size == 3'd3) || (req_size == 3'd6) || (req_size == 3'd7);
    if ((req_size == F3_H || req_size == F3_HU) && req_addr[0]) acc_err = 1'b1;
    if (req_size == F3_W && req_addr[1:0] != 2'b00)              acc_err = 1'b1;
    if (req_addr >= LIMIT)                                        acc_err = 1'b1;
  end
`else
  // Illegal sizes fall back to a word access; misaligned low bits are dropped
  // and upper address bits are ignored so the index wraps.
  always_comb begin
    acc_err  = 1'b0;
    eff_size = req_size;
    if (req_we ? (req_size > F3_W)
               : ((req_size == 3'd3) || (req_size == 3'd6) || (req_size == 3'd7)))
      eff_size = F3_W;
    eff_off = req_addr[1:0];
    if (eff_size == F3_H || eff_size == F3_HU) eff_off[0] = 1'b0;
    else if (eff_size == F3_W)                 eff_off    = 2'b00;
  end

  logic unused_addr;
  assign unused_addr = ^req_addr;
`endif

  always_comb begin
    case (eff_size)
      F3_B:    wdata_rep = {4{req_wdata[7:0]}};
      F3_H:    wdata_rep = {2{req_wdata[15:0]}};
      default: wdata_rep = req_wdata;
    endcase
  end

  assign ram_we = (accept && req_we && !acc_err) ? byte_en(eff_size, eff_off) : 4'b0000;

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_bram (
    .clk  (clk),
    .en   (accept),
    .we   (ram_we),
    .addr (req_addr[AW+1:2]),
    .wdata(wdata_rep),
    .rdata(ram_rdata)
  );

  if (RD_LAT > 1) begin : g_pipe
    logic [31:0] stage [RD_LAT-1];
    always_ff @(posedge clk) begin
      stage[0] <= ram_rdata;
      for (int i = 1; i < RD_LAT - 1; i++) stage[i] <= stage[i-1];
    end
    assign pipe_out = stage[RD_LAT-2];
  end else begin : g_nopipe
    assign pipe_out = ram_rdata;
  end

  // Only one request is ever in flight, so its attributes just need holding.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_we   <= req_we;
      m_err  <= acc_err;
      m_size <= eff_size;
      m_off  <= eff_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      rsp_valid <= 1'b0;
    end else if (accept) begin
      cnt       <= 3'd1;
      state     <= (RD_LAT == 1) ? RESP : BUSY;
      rsp_valid <= (RD_LAT == 1);
    end else begin
      case (state)
        BUSY: begin
          cnt <= cnt + 3'd1;
          if (cnt + 3'd1 == 3'(RD_LAT)) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            rsp_valid <= 1'b0;
          end
        end
        RESP: begin
          state     <= IDLE;
          cnt       <= 3'd0;
          rsp_valid <= 1'b0;
        end
        default: begin
          cnt       <= 3'd0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    shifted = pipe_out >> {m_off, 3'b000};
    case (m_size)
      F3_B:    ext = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   ext = {24'd0, shifted[7:0]};
      F3_H:    ext = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   ext = {16'd0, shifted[15:0]};
      default: ext = pipe_out;
    endcase
  end

  assign rsp_rdata = (rsp_valid && !m_we && !m_err) ? ext : 32'd0;

`ifdef DMEM_ERR_EN
  assign rsp_err = rsp_valid && m_err;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the RISC-V core. It replaces the bare word-wide data RAM hookup with a valid/ready request port and RISC-V load/store sizing: LB/LH/LW/LBU/LHU and SB/SH/SW. It adds byte-lane writes, sign/zero extension, configurable read latency and error reporting. It sits between the CPU memory stage and an internal byte-enable RAM, all on the rising edge of clk.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words; byte address range is 0 .. DEPTH_WORDS*4-1.
RD_LAT, 1, cycles from request accept to response; legal range 1..4.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request this cycle.
req_we  input  1  1 = store, 0 = load.
req_size  input  3  RISC-V funct3 of the load/store.
req_addr  input  32  byte address.
req_wdata  input  32  store data; lanes taken from the LSBs.
rsp_valid  output  1  one-cycle response strobe.
rsp_rdata  output  32  extended load data; 0 for stores and errors.
rsp_err  output  1  access error, qualified by rsp_valid.

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0. RAM contents are not cleared.
- Accept condition: req_valid && req_ready in cycle T. Request fields are registered at the T edge.
- Response timing: exactly one response, with rsp_valid high for one cycle in cycle T+RD_LAT.
- req_ready is high when the counter is 0 or in the response cycle, so back-to-back throughput is one request per RD_LAT cycles. With RD_LAT=1 the controller accepts every cycle.
- Write timing: stores write the RAM at the accept edge. A load issued in the next accepted request sees the new data (no hazard).
- State machine:
  - IDLE: counter=0.
  - BUSY: counter 1..RD_LAT-1.
  - RESP: counter=RD_LAT.
  - RESP moves to IDLE, or directly to BUSY/RESP if a new request is accepted in the same cycle.
- Store byte enables:
  - SB: lane addr[1:0].
  - SH: lanes {addr[1],0} and {addr[1],1}.
  - SW: all four lanes.
  - Data is replicated across lanes (byte x4, half x2).
- Load data: LB/LH sign-extend and LBU/LHU zero-extend the selected lane(s); LW returns the full word.
- Error conditions (rsp_err=1, rsp_rdata=0, no RAM write):
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - addr >= DEPTH_WORDS*4;
  - load funct3 in {3,6,7};
  - store funct3 > 2.
- Ignored inputs: req_valid while req_ready=0 is ignored, and fields are not sampled.
- Reset mid-operation: any in-flight response is dropped (rsp_valid stays 0). A store already accepted remains written.
- The RAM word index is addr[$clog2(DEPTH_WORDS)+1:2]; upper bits are used only for the range check.

Optional Feature:
DMEM_ERR_EN
- Defined: misalignment, range and funct3 checks as above, and rsp_err driven.
- Undefined: rsp_err tied 0 and no checks are made.
  - Low address bits beyond the access size are truncated: halfword addr[0] forced to 0, word addr[1:0] forced to 0.
  - Out-of-range addresses wrap modulo DEPTH_WORDS.
  - Illegal load funct3 is treated as LW; illegal store funct3 is treated as SW.

Decomposition:
- Package dmem_pkg:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5;
  - state enum {IDLE, BUSY, RESP};
  - function computing the 4-bit byte enable from size and addr[1:0].
- Sub-module dmem_bram:
  - DEPTH_WORDS x 32 RAM with 4-bit byte-write enable and registered read;
  - extra RD_LAT-1 output pipeline stages live in dmem_ctrl.

Test Plan:
- SW 0x10 data 0xDEADBEEF, then LW 0x10 (RD_LAT=1) -> rsp_valid one cycle after each accept; rdata=0xDEADBEEF; req_ready held 1.
- SB 0x13 data 0x000000AA, then LW 0x10 -> 0xAAADBEEF; LB 0x13 -> 0xFFFFFFAA; LBU 0x13 -> 0x000000AA; LH 0x12 -> 0xFFFFAAAD; LHU 0x12 -> 0x0000AAAD.
- With DMEM_ERR_EN: LW 0x11, SH 0x13 and LW 0x400 (DEPTH_WORDS=256) -> rsp_err=1, rdata=0; a follow-up LW 0x10 still returns 0xAAADBEEF.
- Without DMEM_ERR_EN: LW 0x11 -> returns the word at 0x10 with rsp_err=0; LW 0x410 -> returns the word at 0x10.
- RD_LAT=3, three back-to-back loads with req_valid held high -> accepts in cycles 0, 3, 6; rsp_valid in cycles 3, 6, 9; req_ready low in cycles 1-2, 4-5 and 7-8.
- RD_LAT=3: accept LW, assert rst in cycle 1 -> no rsp_valid is produced; outputs return to reset values; a prior SW value is intact on a later load.
